// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART transmitter
package uart_pkg;

   localparam int DATA_W = 8;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   function automatic int calc_clks_per_bit(input int clk_freq, input int baud_rate);
      return clk_freq / baud_rate;
   endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: power-of-two byte FIFO; push ignored when full, pop ignored when empty
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic              pop,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] dout,
   output logic              full,
   output logic              empty
);

   localparam int AW = $clog2(FIFO_DEPTH);

   logic [DATA_W-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]     wp, rp;
   logic [AW:0]       count;
   logic              do_push, do_pop;

   assign full    = count == (AW+1)'(FIFO_DEPTH);
   assign empty   = count == '0;
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rp];

   // storage array, written at the write pointer on an accepted push
   always_ff @(posedge clk) begin
      if (do_push) mem[wp] <= din;
   end

   // pointers wrap naturally because the depth is a power of two
   always_ff @(posedge clk) begin
      if (rst) begin
         wp    <= '0;
         rp    <= '0;
         count <= '0;
      end else begin
         if (do_push) wp <= wp + 1'b1;
         if (do_pop) rp <= rp + 1'b1;
         count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
      end
   end

endmodule

// File: rtl/uart_tx.sv
// uart_tx: buffered 8N1 serial transmitter with back-to-back framing
module uart_tx
   import uart_pkg::*;
#(
   parameter int CLK_FREQ     = 50000000,
   parameter int BAUD_RATE    = 9600,
   parameter int CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ, BAUD_RATE),
   parameter int FIFO_DEPTH   = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] data_in,
   input  logic              data_valid,
   output logic              ready,
   output logic              tx,
   output logic              busy
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

   state_t            state;
   logic [CW-1:0]     cnt;
   logic [2:0]        idx;
   logic [DATA_W-1:0] sh, head;
   logic              full, empty, pop, wrap, rst_q;

   assign wrap  = cnt == LAST;
   assign ready = !full && !rst_q;
   assign pop   = !empty && (state == IDLE || (state == STOP && wrap));
   assign busy  = state != IDLE || !empty;

   uart_tx_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (data_valid && ready),
      .pop   (pop),
      .din   (data_in),
      .dout  (head),
      .full  (full),
      .empty (empty)
   );

   // holds ready low for the cycle following any reset edge
   always_ff @(posedge clk) begin
      rst_q <= rst;
   end

   // frame sequencer; tx is registered from the current state so it trails the state by one cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         idx   <= '0;
         sh    <= '0;
         tx    <= 1'b1;
      end else begin
         tx  <= state == START ? 1'b0 : state == DATA ? sh[0] : 1'b1;
         cnt <= (state == IDLE || wrap) ? '0 : cnt + 1'b1;
         case (state)
            IDLE: if (pop) begin
               state <= START;
               sh    <= head;
            end
            START: if (wrap) state <= DATA;
            DATA: if (wrap) begin
               sh  <= sh >> 1;
               idx <= idx + 1'b1;
               if (idx == 3'd7) state <= STOP;
            end
            STOP: if (wrap) begin
               state <= pop ? START : IDLE;
               if (pop) sh <= head;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed and random checks of uart_tx against a frame-level line model
module tb_uart_tx;

   logic       clk = 1'b0, rst = 1'b1, data_valid = 1'b0;
   logic [7:0] data_in = '0;
   logic       ready, tx, busy;

   int         cyc = 0, errors = 0, checks = 0, acc_t;
   logic [9:0] rx_b[$];
   int         rx_t[$];
   logic [7:0] exp_q[$];

   uart_tx #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .FIFO_DEPTH(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .data_in    (data_in),
      .data_valid (data_valid),
      .ready      (ready),
      .tx         (tx),
      .busy       (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [9:0] frame(input logic [7:0] b);
      return {1'b1, b, 1'b0};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] b);
      int k = 0;
      while (!ready && k < 2000) begin
         step(1);
         k++;
      end
      chk("ready_wait", ready, 1);
      data_in = b;
      data_valid = 1'b1;
      step(1);
      data_valid = 1'b0;
      acc_t = cyc;
      exp_q.push_back(b);
   endtask

   task automatic wait_rx(input int n, input int budget);
      int k = 0;
      while (rx_b.size() < n && k < budget) begin
         step(1);
         k++;
      end
      chk("rx_count", rx_b.size(), n);
   endtask

   task automatic check_next(input string tag, output int t);
      logic [7:0] e;
      logic [9:0] got;
      e = exp_q.size() > 0 ? exp_q.pop_front() : 8'h00;
      got = rx_b.size() > 0 ? rx_b.pop_front() : 10'h3ff;
      t = rx_t.size() > 0 ? rx_t.pop_front() : -1;
      chk(tag, got, frame(e));
   endtask

   task automatic wait_idle();
      int k = 0;
      while (busy && k < 2000) begin
         step(1);
         k++;
      end
      chk("idle_wait", busy, 0);
   endtask

   // line receiver: samples every bit mid-period, drops frames cut by reset
   initial begin
      int t0;
      logic [9:0] bits;
      bit ab;
      forever begin
         @(posedge clk);
         #1;
         if (!rst && tx === 1'b0) begin
            t0 = cyc;
            bits = '0;
            ab = 1'b0;
            for (int c = 1; c < 100; c++) begin
               @(posedge clk);
               #1;
               if (rst) ab = 1'b1;
               if (c % 10 == 5) bits[c/10] = tx;
            end
            if (!ab) begin
               rx_b.push_back(bits);
               rx_t.push_back(t0);
            end
         end
      end
   end

   initial begin
      int a0, t1, t2, t3, t4, t5, n_acc, r_t, lows, k;
      logic ok;
      step(3);
      chk("rst_tx", tx, 1);
      chk("rst_busy", busy, 0);
      chk("rst_ready", ready, 0);
      rst = 1'b0;
      step(1);
      chk("ready_after_rst", ready, 1);
      chk("busy_after_rst", busy, 0);

      send(8'hA5);
      a0 = acc_t;
      chk("busy_buffered", busy, 1);
      step(a0 + 97 - cyc);
      chk("busy_in_stop", busy, 1);
      step(5);
      chk("busy_after_stop", busy, 0);
      chk("tx_idle_after", tx, 1);
      wait_rx(1, 300);
      check_next("a5_frame", t1);
      chk("a5_latency", t1 - a0, 2);

      send(8'h00);
      a0 = acc_t;
      send(8'hFF);
      send(8'h55);
      wait_rx(3, 500);
      check_next("b2b_00", t1);
      check_next("b2b_ff", t2);
      check_next("b2b_55", t3);
      chk("b2b_latency", t1 - a0, 2);
      chk("b2b_gap1", t2 - t1, 100);
      chk("b2b_gap2", t3 - t2, 100);
      wait_idle();

      step(20);
      n_acc = 0;
      a0 = 0;
      for (int i = 0; i < 10; i++) begin
         data_in = 8'h10 + 8'(i);
         data_valid = 1'b1;
         ok = ready;
         if (ok) begin
            n_acc++;
            exp_q.push_back(data_in);
         end
         step(1);
         if (ok && n_acc == 1) a0 = cyc;
      end
      data_valid = 1'b0;
      chk("fill_accepts", n_acc, 5);
      chk("fill_ready", ready, 0);
      k = 0;
      while (!ready && k < 300) begin
         step(1);
         k++;
      end
      r_t = cyc;
      chk("ready_return", ready, 1);
      wait_rx(5, 700);
      check_next("fill_0", t1);
      check_next("fill_1", t2);
      check_next("fill_2", t3);
      check_next("fill_3", t4);
      check_next("fill_4", t5);
      chk("fill_latency", t1 - a0, 2);
      chk("ready_rise", r_t, t2 - 1);
      chk("fill_contig", t5 - t1, 400);
      wait_idle();

      step(10);
      send(8'h3C);
      a0 = acc_t;
      step(a0 + 37 - cyc);
      rst = 1'b1;
      step(1);
      chk("abort_tx", tx, 1);
      chk("abort_busy", busy, 0);
      chk("abort_ready", ready, 0);
      exp_q.delete();
      step(2);
      rst = 1'b0;
      lows = 0;
      for (int i = 0; i < 150; i++) begin
         step(1);
         if (tx !== 1'b1) lows++;
      end
      chk("abort_no_frame", lows, 0);
      chk("abort_rx_empty", rx_b.size(), 0);
      chk("abort_idle", busy, 0);
      send(8'h81);
      wait_rx(1, 300);
      check_next("post_abort_81", t1);
      chk("post_abort_latency", t1 - acc_t, 2);

      for (int i = 0; i < 256; i++) send(8'($urandom_range(0, 255)));
      wait_rx(256, 2000);
      for (int i = 0; i < 256; i++) check_next("loopback", t1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter CLK_FREQ, default 50000000, clock frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 9600, line bit rate in bits/s.
REQ-003 Parameter CLKS_PER_BIT, default CLK_FREQ / BAUD_RATE (5208), clock cycles per bit period; SHALL be at least 2.
REQ-004 Parameter FIFO_DEPTH, default 4, transmit buffer entries; SHALL be a power of two, at least 2.
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 data_in  input  8  byte to transmit.
REQ-008 data_valid  input  1  data_in is offered this cycle.
REQ-009 ready  output  1  the block accepts a byte this cycle.
REQ-010 tx  output  1  serial line, registered, idle high.
REQ-011 busy  output  1  a frame is in progress or a byte is buffered.

Function
REQ-012 A byte SHALL be accepted on a rising edge where data_valid=1 and ready=1, and written into the FIFO on that edge.
REQ-013 ready SHALL be 1 exactly when the FIFO is not full; a write while full SHALL be impossible.
REQ-014 data_in and data_valid are ignored when ready=0; no byte is lost or duplicated.
REQ-015 The frame SHALL be 8N1: one start bit (0), 8 data bits LSB first, one stop bit (1), each held exactly CLKS_PER_BIT cycles.
REQ-016 The FSM SHALL have states IDLE, START, DATA, STOP.
REQ-017 IDLE -> START when the FIFO is non-empty: pop the head byte into the shift register and drive tx=0 from the next edge.
REQ-018 START -> DATA after CLKS_PER_BIT cycles; DATA -> STOP after 8 bit periods; STOP -> START after CLKS_PER_BIT cycles if the FIFO is non-empty, else STOP -> IDLE.
REQ-019 Back-to-back frames SHALL have no idle gap: the next start bit begins on the cycle after the last stop-bit cycle.
REQ-020 Latency: with FIFO empty and FSM in IDLE, tx SHALL fall on the second rising edge after the accept edge.
REQ-021 Each frame SHALL occupy exactly 10*CLKS_PER_BIT cycles.
REQ-022 The bit counter SHALL be ceil(log2(CLKS_PER_BIT)) bits wide (13 at defaults) and wrap to 0 at CLKS_PER_BIT-1.
REQ-023 The bit index SHALL be 3 bits and count 0..7 in DATA.
REQ-024 A push and a pop on the same edge SHALL be handled:
- FIFO not full and not empty: occupancy unchanged, both take effect.
- FIFO full: the pop takes effect and no push occurs (ready was 0).
- FIFO empty: the push takes effect and the pop waits one cycle.
REQ-025 FIFO pointers SHALL wrap modulo FIFO_DEPTH; bytes are transmitted in acceptance order.
REQ-026 busy SHALL be 1 whenever the FSM is not IDLE or the FIFO is non-empty, and 0 otherwise.
REQ-027 tx SHALL be 1 in IDLE and STOP, 0 in START, and the current data bit in DATA.

Reset
REQ-028 While rst=1 on an edge:
- tx=1, busy=0, ready=0.
- FSM in IDLE; FIFO empty; bit counter and bit index at 0.
REQ-029 ready SHALL become 1 on the first edge after rst deasserts.
REQ-030 rst asserted mid-frame SHALL abort the frame: tx is 1 from the next edge and buffered bytes are discarded.

Structure
REQ-031 Package uart_pkg SHALL hold:
- the FSM state enum (IDLE, START, DATA, STOP);
- a function computing CLKS_PER_BIT from CLK_FREQ and BAUD_RATE;
- the data-width constant, 8.
REQ-032 The FIFO SHALL be a separate sub-module uart_tx_fifo with push, pop, full, empty and data ports, parameterised by FIFO_DEPTH.

Verification
All scenarios use CLK_FREQ=1000000 and BAUD_RATE=100000, giving CLKS_PER_BIT=10.
REQ-033 Single byte: send 0xA5 once.
- tx falls 2 edges after accept.
- Sampled bits over 100 cycles: 0,1,0,1,0,0,1,0,1,1.
- busy falls after the stop bit.
REQ-034 Back-to-back: send 0x00, 0xFF, 0x55 consecutively.
- Three frames span 300 contiguous cycles with no idle high between the stop bit and the next start bit.
- Bytes are decoded in order.
REQ-035 Full FIFO: hold data_valid=1 for 10 cycles with incrementing data.
- Exactly 5 bytes are accepted (1 popped plus 4 buffered), after which ready=0.
- ready returns to 1 one cycle after each subsequent pop.
REQ-036 Reset mid-frame: assert rst at cycle 35 of a frame carrying 0x3C.
- tx=1 and busy=0 on the next edge.
- No further frame is sent.
- After release, 0x81 transmits correctly.
REQ-037 Loopback: connect tx to the existing receiver (CLKS_PER_BIT=10) and send 256 random bytes; every byte is received with data_valid and matches.
